// File: rtl/perceptron_seq.sv
// Four-neuron binary perceptron sharing one 8-bit accumulator.
// Result is the AND of all activations; config writes land only in IDLE.
module perceptron_seq #(
  parameter logic [7:0] THRESHOLD = 8'd8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [7:0]  cfg_wdata,
  output logic        cfg_err,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_result,
  output logic [15:0] infer_count
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    EVAL,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [3:0][7:0] w_q, w_d;
  logic [7:0]      bias_q, bias_d;
  logic [7:0]      sum_q, sum_d;
  logic [7:0]      data_q, data_d;
  logic [1:0]      n_q, n_d;
  logic [2:0]      i_q, i_d;
  logic            flag_q, flag_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [7:0] addend;
  logic [7:0] biased;
  logic       fire;
  logic       idle;
  logic       mapped;

  assign idle   = (state_q == IDLE);
  assign mapped = (cfg_addr <= 3'd4);
  assign addend = data_q[i_q] ? w_q[n_q] : 8'd0;
  assign biased = sum_q + bias_q;
  assign fire   = (biased >= THRESHOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = ACC;
      ACC:  if (i_q == 3'd7) state_d = EVAL;
      EVAL: state_d = (n_q == 2'd3) ? DONE : ACC;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = idle;
    out_valid   = (state_q == DONE);
    out_result  = out_valid & flag_q;
    cfg_err     = err_q;
    infer_count = cnt_q;
  end

  always_comb begin
    w_d    = w_q;
    bias_d = bias_q;
    sum_d  = sum_q;
    data_d = data_q;
    n_d    = n_q;
    i_d    = i_q;
    flag_d = flag_q;
    cnt_d  = cnt_q;
    err_d  = cfg_we & mapped & ~idle;
    // A same-cycle write and accept both land; ACC reads the new value.
    if (idle && cfg_we) begin
      unique case (1'b1)
        cfg_addr[2]: if (cfg_addr[1:0] == 2'd0) bias_d = cfg_wdata;
        default:     w_d[cfg_addr[1:0]] = cfg_wdata;
      endcase
    end
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d = in_data;
          n_d    = 2'd0;
          i_d    = 3'd0;
          sum_d  = 8'd0;
          flag_d = 1'b1;
        end
      end
      ACC: begin
        sum_d = sum_q + addend;
        i_d   = i_q + 3'd1;
      end
      EVAL: begin
        flag_d = flag_q & fire;
        sum_d  = 8'd0;
        i_d    = 3'd0;
        n_d    = n_q + 2'd1;
      end
      DONE: begin
        if (out_ready) cnt_d = cnt_q + 16'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q    <= '0;
      bias_q <= 8'd0;
      sum_q  <= 8'd0;
      data_q <= 8'd0;
      n_q    <= 2'd0;
      i_q    <= 3'd0;
      flag_q <= 1'b0;
      cnt_q  <= 16'd0;
      err_q  <= 1'b0;
    end else begin
      w_q    <= w_d;
      bias_q <= bias_d;
      sum_q  <= sum_d;
      data_q <= data_d;
      n_q    <= n_d;
      i_q    <= i_d;
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_perceptron_seq.sv
// Randomised bench for perceptron_seq against a popcount-based model.
// Directed cases cover wrap, bias, backpressure, lockout, reset and count wrap.
module tb_perceptron_seq;

  localparam logic [7:0] THR = 8'd8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = 3'd0;
  logic [7:0]  cfg_wdata = 8'd0;
  logic        cfg_err;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_result;
  logic [15:0] infer_count;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mw [4];
  logic [7:0]  mb;
  logic [15:0] mcnt;

  perceptron_seq #(.THRESHOLD(THR)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_err     (cfg_err),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .infer_count (infer_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_res(input logic [7:0] d);
    int pc;
    logic r;
    pc = $countones(d);
    r = 1'b1;
    for (int n = 0; n < 4; n++) begin
      if (((int'(mw[n]) * pc + int'(mb)) % 256) < int'(THR)) r = 1'b0;
    end
    return r;
  endfunction

  task automatic model_cfg(input logic [2:0] a, input logic [7:0] d);
    if (a < 3'd4) mw[a[1:0]] = d;
    else if (a == 3'd4) mb = d;
  endtask

  task automatic model_reset();
    for (int n = 0; n < 4; n++) mw[n] = 8'd0;
    mb = 8'd0;
    mcnt = 16'd0;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    model_cfg(a, d);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    chk("cfg_err_idle", cfg_err, 0);
  endtask

  task automatic run_infer(input logic [7:0] d, input int hold, input bit lock,
                           input bit cw, input logic [2:0] cwa,
                           input logic [7:0] cwd);
    int edges;
    logic expr;
    @(negedge clk);
    chk("rdy_idle", in_ready, 1);
    in_valid = 1'b1;
    in_data = d;
    if (cw) begin
      cfg_we = 1'b1;
      cfg_addr = cwa;
      cfg_wdata = cwd;
      model_cfg(cwa, cwd);
    end
    expr = model_res(d);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 60) begin
      in_valid = 1'($urandom);
      in_data = 8'($urandom);
      @(posedge clk);
      #1;
      edges++;
      if (edges == 20) chk("res_low_busy", out_result, 0);
      if (lock && edges == 3) begin
        cfg_we = 1'b1;
        cfg_addr = 3'd4;
        cfg_wdata = 8'hF8;
      end
      if (lock && edges == 4) begin
        chk("lock_err_hi", cfg_err, 1);
        cfg_we = 1'b0;
      end
      if (lock && edges == 5) chk("lock_err_lo", cfg_err, 0);
    end
    in_valid = 1'b0;
    chk("latency", edges, 36);
    chk("result", out_result, expr);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_result", out_result, expr);
      chk("bp_ready", in_ready, 0);
      chk("bp_count", infer_count, mcnt);
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    mcnt = mcnt + 16'd1;
    chk("count", infer_count, mcnt);
    chk("rdy_after", in_ready, 1);
    chk("vld_after", out_valid, 0);
    in_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    #2;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_count", infer_count, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int n = 0; n < 4; n++) cfg_write(3'(n), 8'd1);
    cfg_write(3'd4, 8'd0);
    run_infer(8'hFF, 0, 0, 0, 3'd0, 8'd0);
    run_infer(8'h7F, 0, 0, 0, 3'd0, 8'd0);

    cfg_write(3'd0, 8'h40);
    run_infer(8'hFF, 0, 0, 0, 3'd0, 8'd0);
    cfg_write(3'd4, 8'h08);
    run_infer(8'hFF, 0, 0, 0, 3'd0, 8'd0);

    cfg_write(3'd6, 8'h00);
    run_infer(8'hFF, 0, 0, 0, 3'd0, 8'd0);
    run_infer(8'hFF, 20, 0, 0, 3'd0, 8'd0);

    cfg_write(3'd0, 8'd1);
    cfg_write(3'd4, 8'd0);
    run_infer(8'hFF, 0, 1, 0, 3'd0, 8'd0);
    run_infer(8'hFF, 0, 0, 1, 3'd4, 8'hF8);

    for (int t = 0; t < 20; t++) begin
      for (int n = 0; n < 4; n++) cfg_write(3'(n), 8'($urandom_range(0, 40)));
      cfg_write(3'd4, 8'($urandom));
      run_infer(8'($urandom), $urandom_range(0, 3), 0, 1'($urandom),
                3'($urandom_range(0, 7)), 8'($urandom));
    end

    @(negedge clk);
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    mcnt = 16'hFFFF;
    chk("cnt_preload", infer_count, 16'hFFFF);
    run_infer(8'h0F, 0, 0, 0, 3'd0, 8'd0);
    chk("cnt_wrapped", infer_count, 16'h0000);
    run_infer(8'h01, 0, 0, 0, 3'd0, 8'd0);

    for (int n = 0; n < 4; n++) cfg_write(3'(n), 8'd1);
    cfg_write(3'd4, 8'd8);
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 8'hFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", infer_count, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_infer(8'hFF, 0, 0, 0, 3'd0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/perceptron_seq.md
PERCEPTRON_SEQ -- requirements
Module: perceptron_seq

Interface
REQ-001 Parameter THRESHOLD, default 8'd8, is the activation threshold; a neuron fires when its biased sum is >= THRESHOLD.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 cfg_we  input  1  configuration write strobe.
REQ-005 cfg_addr  input  3  0-3 select weight[0..3]; 4 selects bias; 5-7 are unmapped.
REQ-006 cfg_wdata  input  8  configuration write data.
REQ-007 cfg_err  output  1  one-cycle pulse when a write is dropped.
REQ-008 in_valid  input  1  input vector valid.
REQ-009 in_ready  output  1  block can accept an input vector.
REQ-010 in_data  input  8  input bit vector.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_result  output  1  AND of the four neuron activations.
REQ-014 infer_count  output  16  count of completed inferences; a result handshake completes an inference.

Function
REQ-015 The block shall hold weight[0..3] and bias in 8-bit registers, serialising one shared accumulator over 4 neurons x 8 input bits.
REQ-016 States shall be IDLE, ACC, EVAL and DONE; in_ready shall be 1 only in IDLE.
REQ-017 IDLE shall go to ACC on in_valid&&in_ready, latching in_data and setting neuron index n=0, bit index i=0, sum=0 and the result flag to 1.
REQ-018 Each ACC cycle shall do sum = (sum + (in_bit[i] ? weight[n] : 0)) mod 256, then i++; after i==7 the next state shall be EVAL.
REQ-019 Each EVAL cycle shall do flag = flag & (((sum + bias) mod 256) >= THRESHOLD), clear sum and i, and then either increment n and return to ACC (n<3) or go to DONE (n==3).
REQ-020 All additions shall be unsigned 8-bit with wrap-around; no saturation and no carry shall be retained.
REQ-021 Latency: out_valid shall rise exactly 36 rising edges after the accepting edge (4 x (8 ACC + 1 EVAL)).
REQ-022 In DONE, out_valid=1 and out_result=flag shall be held stable until out_ready=1.
REQ-023 On out_valid&&out_ready, the block shall increment infer_count (16-bit wrap, 0xFFFF->0x0000) and go to IDLE.
REQ-024 in_ready shall reassert on the cycle after the result handshake; no new input shall be accepted in the same cycle as a result handshake.
REQ-025 A config write shall take effect only in IDLE.
REQ-026 A cfg_we in ACC, EVAL or DONE shall be dropped and shall pulse cfg_err for exactly one cycle.
REQ-027 A cfg_we to addresses 5-7 shall be dropped with no cfg_err.
REQ-028 If a config write and an input accept occur in the same IDLE cycle, the inference shall use the newly written value.
REQ-029 in_data and in_valid shall be ignored outside IDLE.
REQ-030 out_result shall be 0 whenever out_valid=0.

Reset
REQ-031 While rst_n=0, the block shall asynchronously force state=IDLE, weights=0, bias=0, sum=0, n=0, i=0 and infer_count=0.
REQ-032 During reset, the outputs shall be in_ready=1, out_valid=0, out_result=0 and cfg_err=0.
REQ-033 A reset mid-inference shall discard the in-flight inference and shall not increment infer_count.
REQ-034 The first input shall be acceptable on the first rising edge after rst_n deasserts.

Verification
REQ-035 Basic fire, with weights all 1, bias 0, THRESHOLD 8: in_data 0xFF -> out_result 1 with out_valid at edge 36 after accept; in_data 0x7F -> out_result 0.
REQ-036 Wrap and bias: set weight[0]=0x40 and in_data 0xFF, giving sum 0x00. With bias 0 -> out_result 0; with bias 0x08 (others 1) -> out_result 1.
REQ-037 Backpressure: hold out_ready=0 for 20 cycles -> out_valid and out_result stay stable, in_ready=0, infer_count unchanged; release -> infer_count +1 and in_ready=1 next cycle.
REQ-038 Config lockout: cfg_we to addr 4 during ACC -> cfg_err pulses 1 cycle and bias is unchanged; cfg_we to addr 6 in IDLE -> no register changes and cfg_err=0.
REQ-039 Reset mid-run: assert rst_n=0 at edge 15 of an inference -> immediate IDLE, out_valid=0, weights=0, infer_count=0.
REQ-040 Counter wrap: preload 65535 completions (or force) and complete one more inference -> infer_count=0x0000.
